// File: rtl/ped_request.sv
// rtl/ped_request.sv - pedestrian request front end: button conditioning, request latch, walk countdown.
// Define PED_FLASH_EN to flash the walk lamp during the final FLASH_SEC seconds.

module ped_channel #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter logic [7:0]  WALK_SEC   = 8'd15,
    parameter logic [7:0]  FLASH_SEC  = 8'd5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       btn_i,
    input  logic       grant_i,
    output logic       req_o,
    output logic       walk_o,
    output logic       done_o,
    output logic [7:0] walk_cnt_o
);
    typedef enum logic [1:0] {IDLE, PEND, WALK} state_t;

    state_t      state_q;
    logic        sync1_q, sync2_q;
    logic        deb_q, deb_d;
    logic        deb_prev_q, press_q;
    logic [15:0] deb_cnt_q, deb_cnt_d;
    logic        req_q, walk_q, done_q;
    logic [7:0]  cnt_q;

    // Lamp level for a remaining-seconds value; only ever evaluated for counts >= 1.
    function automatic logic walk_level(input logic [7:0] n);
`ifdef PED_FLASH_EN
        return (n > FLASH_SEC) ? 1'b1 : n[0];
`else
        return (n != 8'd0) || (n > FLASH_SEC);
`endif
    endfunction

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_CYCLES - 16'd1) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_cnt_q  <= '0;
            deb_prev_q <= 1'b0;
            press_q    <= 1'b0;
            req_q      <= 1'b0;
            walk_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (press_q) begin
                        state_q <= PEND;
                        req_q   <= 1'b1;
                    end
                end
                PEND: begin
                    // A grant here always wins; a coincident tick is not counted.
                    if (grant_i) begin
                        state_q <= WALK;
                        req_q   <= 1'b0;
                        cnt_q   <= WALK_SEC;
                        walk_q  <= walk_level(WALK_SEC);
                    end
                end
                WALK: begin
                    if (tick_i) begin
                        if (cnt_q > 8'd1) begin
                            cnt_q  <= cnt_q - 8'd1;
                            walk_q <= walk_level(cnt_q - 8'd1);
                        end else begin
                            cnt_q   <= '0;
                            walk_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    walk_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign req_o      = req_q;
    assign walk_o     = walk_q;
    assign done_o     = done_q;
    assign walk_cnt_o = cnt_q;
endmodule

module ped_request #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter logic [7:0]  WALK_SEC   = 8'd15,
    parameter logic [7:0]  FLASH_SEC  = 8'd5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Btn_NS,
    input  logic       Btn_EW,
    input  logic       Grant_NS,
    input  logic       Grant_EW,
    output logic       Req_NS,
    output logic       Req_EW,
    output logic       Walk_NS,
    output logic       Walk_EW,
    output logic       Done_NS,
    output logic       Done_EW,
    output logic [7:0] Walk_cnt_NS,
    output logic [7:0] Walk_cnt_EW
);
    ped_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .WALK_SEC   (WALK_SEC),
        .FLASH_SEC  (FLASH_SEC)
    ) u_ns (
        .clk_i      (Clk),
        .rst_ni     (Reset),
        .tick_i     (Tick),
        .btn_i      (Btn_NS),
        .grant_i    (Grant_NS),
        .req_o      (Req_NS),
        .walk_o     (Walk_NS),
        .done_o     (Done_NS),
        .walk_cnt_o (Walk_cnt_NS)
    );

    ped_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .WALK_SEC   (WALK_SEC),
        .FLASH_SEC  (FLASH_SEC)
    ) u_ew (
        .clk_i      (Clk),
        .rst_ni     (Reset),
        .tick_i     (Tick),
        .btn_i      (Btn_EW),
        .grant_i    (Grant_EW),
        .req_o      (Req_EW),
        .walk_o     (Walk_EW),
        .done_o     (Done_EW),
        .walk_cnt_o (Walk_cnt_EW)
    );
endmodule
